ssg_frame_assembler: RTL and testbench
======================================

# ssg_frame_assembler

Transmit-side counterpart of the SSG frame consumer. It accepts a word stream on two parallel lanes, one WEIGHT-bit word per lane per transfer, and assembles WIDTH consecutive transfers into the two unpacked 2D ports `some_2d_port_1` and `some_2d_port_2`. A valid/ready handshake presents each completed frame. Two register banks (fill and output) let the next frame be assembled while the current one waits for the consumer.

## Interface
- `WEIGHT`, 5: bits per word, i.e. the packed dimension of each output port.
- `WIDTH`, 2: words per frame, i.e. the unpacked dimension; legal values are ≥ 2.
- `X`, max(1, $clog2(WIDTH)): derived width of the word-index counter; do not override.

- `clk`  in  1  single clock; all state is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  an input word pair is offered.
- `in_ready`  out  1  the block can accept a word pair.
- `in_data_1`  in  WEIGHT  lane-1 word.
- `in_data_2`  in  WEIGHT  lane-2 word.
- `in_last`  in  1  the offered pair is the final word of its frame.
- `out_valid`  out  1  a complete frame is presented.
- `out_ready`  in  1  the consumer takes the frame.
- `some_2d_port_1`  out  [WEIGHT-1:0] x [WIDTH-1:0]  lane-1 frame; entry k is the k-th accepted word.
- `some_2d_port_2`  out  [WEIGHT-1:0] x [WIDTH-1:0]  lane-2 frame, with the same ordering.
- `err_len`  out  1  one-cycle pulse on a frame-length violation (see Configuration).

## Operation
- Input transfer occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- Word index `idx` (X bits) selects the fill-bank entry. Each accepted pair writes entry `idx` of both lanes. `idx` increments and wraps from WIDTH-1 to 0.
- State machine:
  - FILL: `in_ready`=1.
  - FULL: `in_ready`=0. The fill bank holds a complete frame and the output bank is occupied.
- FILL, word at `idx`=WIDTH-1 accepted:
  - If the output bank is free, or is being popped in the same cycle, copy the fill bank plus that word into the output bank, set `out_valid`=1 and stay in FILL.
  - Otherwise go to FULL.
- FULL: on output transfer, copy the fill bank into the output bank, keep `out_valid`=1 and return to FILL.
- Output transfer with no pending frame: `out_valid` goes to 0.
- The output arrays are stable while `out_valid && !out_ready`. After a pop they hold their last value and are not cleared.
- Reset, including mid-frame: `idx`=0, state FILL, `out_valid`=0, `err_len`=0, both output arrays all-zero, fill bank all-zero. Any partial frame is lost.

## Timing
- `in_ready` is a registered function of state only and does not depend combinationally on `out_ready`.
- Latency: the last word is accepted at edge N and `out_valid`=1 from edge N, so the frame is visible in cycle N+1.
- Throughput: one frame per WIDTH cycles when `in_valid` and `out_ready` are held high. There are no bubbles.
- Backpressure: at most one complete frame waits in the fill bank. `in_ready` drops for the cycles spent in FULL.
- Simultaneous events: a last-word accept and an output pop in the same cycle cause no stall, and the new frame replaces the old one at that edge.

## Configuration
- Macro: `SSG_ASM_LAST_CHECK_EN`.
- Defined, early last: `in_last`=1 on an accepted word with `idx`≠WIDTH-1.
  - `err_len` pulses for 1 cycle.
  - The partial frame is discarded and `idx` resets to 0.
  - No output frame is produced.
- Defined, missing last: `in_last`=0 on an accepted word with `idx`=WIDTH-1.
  - `err_len` pulses for 1 cycle.
  - The frame completes normally.
- Not defined: `in_last` is ignored, `err_len` is tied to 0 and framing is purely by count.

## Test plan
- Reset: assert `reset`=0 mid-frame after 1 of 2 words, then release → `out_valid`=0, arrays are 0, and the next 2 words form a frame with no stale data.
- Basic frame, WIDTH=2, WEIGHT=5: send (1,17) then (2,18) with `in_last` on the 2nd and `out_ready`=1 → cycle after the 2nd accept, `out_valid`=1, `some_2d_port_1`={[0]=1,[1]=2}, `some_2d_port_2`={[0]=17,[1]=18}.
- Streaming: 8 back-to-back frames with `out_ready`=1 → `in_ready` constantly 1 and 8 frames out in order, one per 2 cycles.
- Backpressure: `out_ready`=0 while 2 frames are sent → first frame held stable, state FULL, `in_ready`=0 on the 3rd offer. Raise `out_ready` for 1 cycle → second frame presented next cycle and `in_ready`=1.
- Same-cycle pop and complete: pop frame A on the same edge that the last word of frame B is accepted → frame B is presented next cycle and `in_ready` never deasserts.
- With `SSG_ASM_LAST_CHECK_EN`:
  - `in_last`=1 on word 0 → `err_len`=1 for one cycle, no frame produced, next 2 words form a valid frame.
  - `in_last`=0 on word 1 → `err_len` pulse and the frame is still delivered.

Source files
------------

// File: rtl/ssg_frame_assembler_if.sv
// Handshake and frame bus between an SSG word producer/consumer and ssg_frame_assembler.
// The master side drives words and out_ready; the slave side (the assembler) drives frames.
interface ssg_frame_assembler_if #(
    parameter int WEIGHT = 5,
    parameter int WIDTH  = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [WEIGHT-1:0] in_data_1;
    logic [WEIGHT-1:0] in_data_2;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [WEIGHT-1:0] some_2d_port_1 [WIDTH-1:0];
    logic [WEIGHT-1:0] some_2d_port_2 [WIDTH-1:0];
    logic              err_len;

    modport master (
        output in_valid, in_data_1, in_data_2, in_last, out_ready,
        input  in_ready, out_valid, some_2d_port_1, some_2d_port_2, err_len
    );

    modport slave (
        input  in_valid, in_data_1, in_data_2, in_last, out_ready,
        output in_ready, out_valid, some_2d_port_1, some_2d_port_2, err_len
    );
endinterface

// File: rtl/ssg_frame_assembler.sv
// Two-lane word-to-frame assembler with a fill bank and an output bank (double buffered).
// Optional frame-length checking of in_last is enabled by defining SSG_ASM_LAST_CHECK_EN.
module ssg_frame_assembler #(
    parameter int WEIGHT = 5,
    parameter int WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    ssg_frame_assembler_if.slave  bus
);
    localparam int X = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [X-1:0] LAST_IDX = X'(WIDTH - 1);

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] FULL = 1'b1;

    logic [0:0]        stateQ, stateD;
    logic [X-1:0]      idxQ, idxD;
    logic              outValidQ, outValidD;
    logic [WEIGHT-1:0] fill1Q [WIDTH-1:0];
    logic [WEIGHT-1:0] fill1D [WIDTH-1:0];
    logic [WEIGHT-1:0] fill2Q [WIDTH-1:0];
    logic [WEIGHT-1:0] fill2D [WIDTH-1:0];
    logic [WEIGHT-1:0] out1Q  [WIDTH-1:0];
    logic [WEIGHT-1:0] out1D  [WIDTH-1:0];
    logic [WEIGHT-1:0] out2Q  [WIDTH-1:0];
    logic [WEIGHT-1:0] out2D  [WIDTH-1:0];

    logic accept;
    logic pop;
    logic atLast;
    logic discard;
    logic errD;

    always_comb begin
        accept = bus.in_valid && (stateQ == FILL);
        pop    = outValidQ && bus.out_ready;
        atLast = (idxQ == LAST_IDX);
`ifdef SSG_ASM_LAST_CHECK_EN
        discard = accept && bus.in_last && !atLast;
        errD    = discard || (accept && !bus.in_last && atLast);
`else
        discard = 1'b0;
        errD    = 1'b0;
`endif

        stateD    = stateQ;
        idxD      = idxQ;
        outValidD = outValidQ;
        fill1D    = fill1Q;
        fill2D    = fill2Q;
        out1D     = out1Q;
        out2D     = out2Q;

        if (pop) begin
            outValidD = 1'b0;
        end

        // A completed frame goes straight to the output bank when it is free or
        // being popped this cycle; otherwise it parks in the fill bank (FULL).
        case (stateQ)
            FILL: begin
                if (discard) begin
                    idxD = '0;
                end else if (accept) begin
                    fill1D[idxQ] = bus.in_data_1;
                    fill2D[idxQ] = bus.in_data_2;
                    idxD = atLast ? '0 : idxQ + X'(1);
                    if (atLast) begin
                        if (!outValidQ || bus.out_ready) begin
                            out1D     = fill1D;
                            out2D     = fill2D;
                            outValidD = 1'b1;
                        end else begin
                            stateD = FULL;
                        end
                    end
                end
            end
            FULL: begin
                if (pop) begin
                    out1D     = fill1Q;
                    out2D     = fill2Q;
                    outValidD = 1'b1;
                    stateD    = FILL;
                end
            end
            default: stateD = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ    <= FILL;
            idxQ      <= '0;
            outValidQ <= 1'b0;
            for (int k = 0; k < WIDTH; k++) begin
                fill1Q[k] <= '0;
                fill2Q[k] <= '0;
                out1Q[k]  <= '0;
                out2Q[k]  <= '0;
            end
        end else begin
            stateQ    <= stateD;
            idxQ      <= idxD;
            outValidQ <= outValidD;
            fill1Q    <= fill1D;
            fill2Q    <= fill2D;
            out1Q     <= out1D;
            out2Q     <= out2D;
        end
    end

`ifdef SSG_ASM_LAST_CHECK_EN
    logic errQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            errQ <= 1'b0;
        end else begin
            errQ <= errD;
        end
    end

    assign bus.err_len = errQ;
`else
    assign bus.err_len = errD;
`endif

    assign bus.in_ready       = (stateQ == FILL);
    assign bus.out_valid      = outValidQ;
    assign bus.some_2d_port_1 = out1Q;
    assign bus.some_2d_port_2 = out2Q;
endmodule

// File: tb/tb_ssg_frame_assembler.sv
// Directed self-checking bench for ssg_frame_assembler (WIDTH=2, WEIGHT=5).
// Length-error scenarios follow SSG_ASM_LAST_CHECK_EN; otherwise in_last must be ignored.
module tb_ssg_frame_assembler;
    localparam int WEIGHT = 5;
    localparam int WIDTH  = 2;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    ssg_frame_assembler_if #(.WEIGHT(WEIGHT), .WIDTH(WIDTH)) bus ();

    ssg_frame_assembler #(.WEIGHT(WEIGHT), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sendWord(input logic [4:0] d1, input logic [4:0] d2, input logic last);
        bus.in_valid  = 1'b1;
        bus.in_data_1 = d1;
        bus.in_data_2 = d2;
        bus.in_last   = last;
        cycle();
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.err_len !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_len got=%b exp=0", bus.err_len); end
        checks++; if ({bus.some_2d_port_1[1], bus.some_2d_port_1[0], bus.some_2d_port_2[1], bus.some_2d_port_2[0]} !== 20'h0)
            begin errors++; $display("[TB] FAIL reset_arrays got=%h exp=0", {bus.some_2d_port_1[1], bus.some_2d_port_1[0], bus.some_2d_port_2[1], bus.some_2d_port_2[0]}); end
        cycle();
        reset = 1'b1;
        cycle();
        sendWord(5'd5, 5'd6, 1'b0);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        cycle();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_out_valid got=%b exp=0", bus.out_valid); end
        sendWord(5'd7, 5'd8, 1'b0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_no_stale got=%b exp=0", bus.out_valid); end
        sendWord(5'd9, 5'd10, 1'b1);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL midreset_frame_valid got=%b exp=1", bus.out_valid); end
        checks++; if ({bus.some_2d_port_1[1], bus.some_2d_port_1[0]} !== {5'd9, 5'd7})
            begin errors++; $display("[TB] FAIL midreset_p1 got=%h exp=%h", {bus.some_2d_port_1[1], bus.some_2d_port_1[0]}, {5'd9, 5'd7}); end
        checks++; if ({bus.some_2d_port_2[1], bus.some_2d_port_2[0]} !== {5'd10, 5'd8})
            begin errors++; $display("[TB] FAIL midreset_p2 got=%h exp=%h", {bus.some_2d_port_2[1], bus.some_2d_port_2[0]}, {5'd10, 5'd8}); end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        cycle();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_pop_empty got=%b exp=0", bus.out_valid); end
        sendWord(5'd1, 5'd17, 1'b0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_partial got=%b exp=0", bus.out_valid); end
        sendWord(5'd2, 5'd18, 1'b1);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid got=%b exp=1", bus.out_valid); end
        checks++; if ({bus.some_2d_port_1[1], bus.some_2d_port_1[0]} !== {5'd2, 5'd1})
            begin errors++; $display("[TB] FAIL basic_p1 got=%h exp=%h", {bus.some_2d_port_1[1], bus.some_2d_port_1[0]}, {5'd2, 5'd1}); end
        checks++; if ({bus.some_2d_port_2[1], bus.some_2d_port_2[0]} !== {5'd18, 5'd17})
            begin errors++; $display("[TB] FAIL basic_p2 got=%h exp=%h", {bus.some_2d_port_2[1], bus.some_2d_port_2[0]}, {5'd18, 5'd17}); end
        cycle();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_after_pop got=%b exp=0", bus.out_valid); end
        checks++; if ({bus.some_2d_port_1[1], bus.some_2d_port_1[0]} !== {5'd2, 5'd1})
            begin errors++; $display("[TB] FAIL basic_hold_after_pop got=%h exp=%h", {bus.some_2d_port_1[1], bus.some_2d_port_1[0]}, {5'd2, 5'd1}); end
    endtask

    task automatic test_streaming();
        int framesSeen;
        logic [4:0] e1;
        logic [4:0] e2;
        framesSeen    = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int f = 0; f < 8; f++) begin
            for (int w = 0; w < 2; w++) begin
                bus.in_data_1 = 5'(2 * f + w);
                bus.in_data_2 = 5'(16 + 2 * f + w);
                bus.in_last   = (w == 1);
                checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_in_ready f=%0d w=%0d got=%b exp=1", f, w, bus.in_ready); end
                cycle();
                if (w == 1) begin
                    e1 = 5'(2 * f);
                    e2 = 5'(16 + 2 * f);
                    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid f=%0d got=%b exp=1", f, bus.out_valid); end
                    else framesSeen++;
                    checks++; if ({bus.some_2d_port_1[1], bus.some_2d_port_1[0], bus.some_2d_port_2[1], bus.some_2d_port_2[0]} !== {e1 + 5'd1, e1, e2 + 5'd1, e2})
                        begin errors++; $display("[TB] FAIL stream_data f=%0d got=%h exp=%h", f,
                            {bus.some_2d_port_1[1], bus.some_2d_port_1[0], bus.some_2d_port_2[1], bus.some_2d_port_2[0]}, {e1 + 5'd1, e1, e2 + 5'd1, e2}); end
                end else begin
                    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_gap f=%0d got=%b exp=0", f, bus.out_valid); end
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        checks++; if (framesSeen !== 8) begin errors++; $display("[TB] FAIL stream_frame_count got=%0d exp=8", framesSeen); end
        cycle();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        sendWord(5'd3, 5'd19, 1'b0);
        sendWord(5'd4, 5'd20, 1'b1);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_first_valid got=%b exp=1", bus.out_valid); end
        sendWord(5'd5, 5'd21, 1'b0);
        sendWord(5'd6, 5'd22, 1'b1);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_in_ready got=%b exp=0", bus.in_ready); end
        bus.in_valid  = 1'b1;
        bus.in_data_1 = 5'd7;
        bus.in_data_2 = 5'd23;
        cycle();
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_third_offer got=%b exp=0", bus.in_ready); end
        checks++; if ({bus.some_2d_port_1[1], bus.some_2d_port_1[0], bus.some_2d_port_2[1], bus.some_2d_port_2[0]} !== {5'd4, 5'd3, 5'd20, 5'd19})
            begin errors++; $display("[TB] FAIL bp_hold_first got=%h exp=%h",
                {bus.some_2d_port_1[1], bus.some_2d_port_1[0], bus.some_2d_port_2[1], bus.some_2d_port_2[0]}, {5'd4, 5'd3, 5'd20, 5'd19}); end
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_second_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if ({bus.some_2d_port_1[1], bus.some_2d_port_1[0], bus.some_2d_port_2[1], bus.some_2d_port_2[0]} !== {5'd6, 5'd5, 5'd22, 5'd21})
            begin errors++; $display("[TB] FAIL bp_second_data got=%h exp=%h",
                {bus.some_2d_port_1[1], bus.some_2d_port_1[0], bus.some_2d_port_2[1], bus.some_2d_port_2[0]}, {5'd6, 5'd5, 5'd22, 5'd21}); end
    endtask

    task automatic test_back_to_back();
        sendWord(5'd8, 5'd24, 1'b0);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_mid_in_ready got=%b exp=1", bus.in_ready); end
        bus.in_valid  = 1'b1;
        bus.in_data_1 = 5'd9;
        bus.in_data_2 = 5'd25;
        bus.in_last   = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if ({bus.some_2d_port_1[1], bus.some_2d_port_1[0], bus.some_2d_port_2[1], bus.some_2d_port_2[0]} !== {5'd9, 5'd8, 5'd25, 5'd24})
            begin errors++; $display("[TB] FAIL b2b_data got=%h exp=%h",
                {bus.some_2d_port_1[1], bus.some_2d_port_1[0], bus.some_2d_port_2[1], bus.some_2d_port_2[0]}, {5'd9, 5'd8, 5'd25, 5'd24}); end
        cycle();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain got=%b exp=0", bus.out_valid); end
    endtask

`ifdef SSG_ASM_LAST_CHECK_EN
    task automatic test_len_check();
        sendWord(5'd10, 5'd26, 1'b1);
        checks++; if (bus.err_len !== 1'b1) begin errors++; $display("[TB] FAIL early_err got=%b exp=1", bus.err_len); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL early_no_frame got=%b exp=0", bus.out_valid); end
        cycle();
        checks++; if (bus.err_len !== 1'b0) begin errors++; $display("[TB] FAIL early_err_pulse got=%b exp=0", bus.err_len); end
        sendWord(5'd11, 5'd27, 1'b0);
        sendWord(5'd12, 5'd28, 1'b1);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL early_next_valid got=%b exp=1", bus.out_valid); end
        checks++; if ({bus.some_2d_port_1[1], bus.some_2d_port_1[0], bus.some_2d_port_2[1], bus.some_2d_port_2[0]} !== {5'd12, 5'd11, 5'd28, 5'd27})
            begin errors++; $display("[TB] FAIL early_next_data got=%h exp=%h",
                {bus.some_2d_port_1[1], bus.some_2d_port_1[0], bus.some_2d_port_2[1], bus.some_2d_port_2[0]}, {5'd12, 5'd11, 5'd28, 5'd27}); end
        checks++; if (bus.err_len !== 1'b0) begin errors++; $display("[TB] FAIL early_next_err got=%b exp=0", bus.err_len); end
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        sendWord(5'd13, 5'd29, 1'b0);
        sendWord(5'd14, 5'd30, 1'b0);
        checks++; if (bus.err_len !== 1'b1) begin errors++; $display("[TB] FAIL missing_err got=%b exp=1", bus.err_len); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL missing_valid got=%b exp=1", bus.out_valid); end
        checks++; if ({bus.some_2d_port_1[1], bus.some_2d_port_1[0]} !== {5'd14, 5'd13})
            begin errors++; $display("[TB] FAIL missing_p1 got=%h exp=%h", {bus.some_2d_port_1[1], bus.some_2d_port_1[0]}, {5'd14, 5'd13}); end
        cycle();
        checks++; if (bus.err_len !== 1'b0) begin errors++; $display("[TB] FAIL missing_err_pulse got=%b exp=0", bus.err_len); end
    endtask
`else
    task automatic test_len_check();
        sendWord(5'd10, 5'd26, 1'b1);
        checks++; if (bus.err_len !== 1'b0) begin errors++; $display("[TB] FAIL nocheck_err got=%b exp=0", bus.err_len); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL nocheck_partial got=%b exp=0", bus.out_valid); end
        sendWord(5'd11, 5'd27, 1'b0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL nocheck_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.err_len !== 1'b0) begin errors++; $display("[TB] FAIL nocheck_err2 got=%b exp=0", bus.err_len); end
        checks++; if ({bus.some_2d_port_1[1], bus.some_2d_port_1[0], bus.some_2d_port_2[1], bus.some_2d_port_2[0]} !== {5'd11, 5'd10, 5'd27, 5'd26})
            begin errors++; $display("[TB] FAIL nocheck_data got=%h exp=%h",
                {bus.some_2d_port_1[1], bus.some_2d_port_1[0], bus.some_2d_port_2[1], bus.some_2d_port_2[0]}, {5'd11, 5'd10, 5'd27, 5'd26}); end
    endtask
`endif

    initial begin
        checks        = 0;
        errors        = 0;
        bus.in_valid  = 1'b0;
        bus.in_data_1 = '0;
        bus.in_data_2 = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_streaming();
        test_backpressure();
        test_back_to_back();
        test_len_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
